// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and default widths for the fetch/decode pipeline stage buffer.
// Holds the occupancy state encoding and the head-register update selector.
package pipe_stage_buf_pkg;

    localparam int DEF_PC_W   = 32;
    localparam int DEF_INSN_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        H_HOLD = 2'd0,
        H_UP   = 2'd1,
        H_SKID = 2'd2,
        H_CLR  = 2'd3
    } head_op_t;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Upstream/downstream handshake, payload, flush and stall-count bundle.
// master = surrounding pipeline (producer + consumer), slave = the stage buffer.
interface pipe_stage_buf_if
    import pipe_stage_buf_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int INSN_W = DEF_INSN_W,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              up_valid;
    logic              up_ready;
    logic [PC_W-1:0]   up_pc;
    logic [PC_W-1:0]   up_pc_plus_4;
    logic [INSN_W-1:0] up_insn;
    logic              dn_valid;
    logic              dn_ready;
    logic [PC_W-1:0]   dn_pc;
    logic [PC_W-1:0]   dn_pc_plus_4;
    logic [INSN_W-1:0] dn_insn;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, up_valid, up_pc, up_pc_plus_4, up_insn, dn_ready,
        input  up_ready, dn_valid, dn_pc, dn_pc_plus_4, dn_insn, stall_cnt
    );

    modport slave (
        input  flush, up_valid, up_pc, up_pc_plus_4, up_insn, dn_ready,
        output up_ready, dn_valid, dn_pc, dn_pc_plus_4, dn_insn, stall_cnt
    );

endinterface

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
// Latency 1 cycle from inc to q; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: registered head (+ optional skid entry), flush kills all; 1-cycle latency.
// SKID=1: up_ready purely registered (~skid full); SKID=0: up_ready = ~dn_valid | dn_ready.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int INSN_W = DEF_INSN_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input logic             sys_clk,
    input logic             sys_rst_n,
    pipe_stage_buf_if.slave bus
);
    state_t            r_state;
    state_t            w_nxt;
    head_op_t          w_h_op;
    logic              r_live;
    logic [PC_W-1:0]   r_h_pc;
    logic [PC_W-1:0]   r_h_pc4;
    logic [INSN_W-1:0] r_h_insn;
    logic [PC_W-1:0]   w_s_pc;
    logic [PC_W-1:0]   w_s_pc4;
    logic [INSN_W-1:0] w_s_insn;
    logic              w_dn_vld;
    logic              w_up_rdy;
    logic              w_acc;
    logic              w_emit;

    assign w_dn_vld = (r_state != ST_EMPTY);
    assign w_emit   = w_dn_vld & bus.dn_ready;
    // r_live blocks capture on the first edge after reset release, so an edge
    // that coincides with deassertion can never load a half-reset stage.
    assign w_acc    = bus.up_valid & w_up_rdy & r_live & ~bus.flush;

    assign bus.up_ready     = w_up_rdy;
    assign bus.dn_valid     = w_dn_vld;
    assign bus.dn_pc        = r_h_pc;
    assign bus.dn_pc_plus_4 = r_h_pc4;
    assign bus.dn_insn      = r_h_insn;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_h_pc   <= '0;
            r_h_pc4  <= '0;
            r_h_insn <= '0;
        end else begin
            case (w_h_op)
                H_UP: begin
                    r_h_pc   <= bus.up_pc;
                    r_h_pc4  <= bus.up_pc_plus_4;
                    r_h_insn <= bus.up_insn;
                end
                H_SKID: begin
                    r_h_pc   <= w_s_pc;
                    r_h_pc4  <= w_s_pc4;
                    r_h_insn <= w_s_insn;
                end
                H_CLR: begin
                    r_h_pc   <= '0;
                    r_h_pc4  <= '0;
                    r_h_insn <= '0;
                end
                default: ;
            endcase
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [PC_W-1:0]   r_s_pc;
            logic [PC_W-1:0]   r_s_pc4;
            logic [INSN_W-1:0] r_s_insn;
            logic              w_s_load;
            logic              w_s_clr;

            assign w_up_rdy = (r_state != ST_FULL);

            always_comb begin
                w_nxt    = r_state;
                w_h_op   = H_HOLD;
                w_s_load = 1'b0;
                w_s_clr  = 1'b0;
                case (r_state)
                    ST_EMPTY: begin
                        if (w_acc) begin
                            w_nxt  = ST_ONE;
                            w_h_op = H_UP;
                        end
                    end
                    ST_ONE: begin
                        if (w_acc && !w_emit) begin
                            w_nxt    = ST_FULL;
                            w_s_load = 1'b1;
                        end else if (w_acc) begin
                            w_h_op = H_UP;
                        end else if (w_emit) begin
                            w_nxt  = ST_EMPTY;
                            w_h_op = H_CLR;
                        end
                    end
                    ST_FULL: begin
                        if (w_emit) begin
                            w_nxt   = ST_ONE;
                            w_h_op  = H_SKID;
                            w_s_clr = 1'b1;
                        end
                    end
                    default: begin
                        w_nxt  = ST_EMPTY;
                        w_h_op = H_CLR;
                    end
                endcase
                if (bus.flush) begin
                    w_nxt    = ST_EMPTY;
                    w_h_op   = H_CLR;
                    w_s_load = 1'b0;
                    w_s_clr  = 1'b1;
                end
            end

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_s_pc   <= '0;
                    r_s_pc4  <= '0;
                    r_s_insn <= '0;
                end else if (w_s_clr) begin
                    r_s_pc   <= '0;
                    r_s_pc4  <= '0;
                    r_s_insn <= '0;
                end else if (w_s_load) begin
                    r_s_pc   <= bus.up_pc;
                    r_s_pc4  <= bus.up_pc_plus_4;
                    r_s_insn <= bus.up_insn;
                end
            end

            assign w_s_pc   = r_s_pc;
            assign w_s_pc4  = r_s_pc4;
            assign w_s_insn = r_s_insn;
        end else begin : g_reg
            assign w_up_rdy = ~w_dn_vld | bus.dn_ready;

            always_comb begin
                w_nxt  = r_state;
                w_h_op = H_HOLD;
                if (bus.flush) begin
                    w_nxt  = ST_EMPTY;
                    w_h_op = H_CLR;
                end else if (w_acc) begin
                    w_nxt  = ST_ONE;
                    w_h_op = H_UP;
                end else if (w_emit || (r_state == ST_FULL)) begin
                    w_nxt  = ST_EMPTY;
                    w_h_op = H_CLR;
                end
            end

            assign w_s_pc   = '0;
            assign w_s_pc4  = '0;
            assign w_s_insn = '0;
        end
    endgenerate

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .inc   (w_dn_vld & ~bus.dn_ready & ~bus.flush),
        .q     (bus.stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: SKID=1 stage driven from a vector table, SKID=0/CNT_W=4 stage by hand sequences.
module tb_pipe_stage_buf;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    pipe_stage_buf_if #(.PC_W(32), .INSN_W(32), .CNT_W(16)) if1 ();
    pipe_stage_buf_if #(.PC_W(32), .INSN_W(32), .CNT_W(4))  if0 ();

    pipe_stage_buf #(.PC_W(32), .INSN_W(32), .SKID(1), .CNT_W(16)) u1 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (if1.slave)
    );

    pipe_stage_buf #(.PC_W(32), .INSN_W(32), .SKID(0), .CNT_W(4)) u0 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        uv;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        dr;
        logic        fl;
        logic        e_dv;
        logic [31:0] e_pc;
        logic [31:0] e_insn;
        logic        e_ur;
        logic [15:0] e_st;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(logic uv, logic [31:0] pc, logic [31:0] insn, logic dr, logic fl,
                                logic e_dv, logic [31:0] e_pc, logic [31:0] e_insn, logic e_ur,
                                logic [15:0] e_st);
        vec_t v;
        v.uv = uv; v.pc = pc; v.insn = insn; v.dr = dr; v.fl = fl;
        v.e_dv = e_dv; v.e_pc = e_pc; v.e_insn = e_insn; v.e_ur = e_ur; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic uv, input logic [31:0] pc, input logic [31:0] insn,
                          input logic dr, input logic fl);
        if1.up_valid     = uv;
        if1.up_pc        = pc;
        if1.up_pc_plus_4 = pc + 32'd4;
        if1.up_insn      = insn;
        if1.dn_ready     = dr;
        if1.flush        = fl;
    endtask

    task automatic drive0(input logic uv, input logic [31:0] pc, input logic [31:0] insn,
                          input logic dr);
        if0.up_valid     = uv;
        if0.up_pc        = pc;
        if0.up_pc_plus_4 = pc + 32'd4;
        if0.up_insn      = insn;
        if0.dn_ready     = dr;
        if0.flush        = 1'b0;
    endtask

    initial begin
        logic [31:0] e_pc4;
        logic [31:0] e_sat;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive1(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive0(1'b0, 32'h0, 32'h0, 1'b0);

        tbl[0]  = mk(1, 32'h000, 32'h00000093, 1, 0, 1, 32'h000, 32'h00000093, 1, 0);
        tbl[1]  = mk(1, 32'h004, 32'h00100113, 1, 0, 1, 32'h004, 32'h00100113, 1, 0);
        tbl[2]  = mk(1, 32'h008, 32'h00200193, 1, 0, 1, 32'h008, 32'h00200193, 1, 0);
        tbl[3]  = mk(0, 32'h000, 32'h00000000, 1, 0, 0, 32'h000, 32'h00000000, 1, 0);
        tbl[4]  = mk(1, 32'h100, 32'hAAAA0001, 0, 0, 1, 32'h100, 32'hAAAA0001, 1, 0);
        tbl[5]  = mk(1, 32'h104, 32'hBBBB0002, 0, 0, 1, 32'h100, 32'hAAAA0001, 0, 1);
        tbl[6]  = mk(1, 32'h108, 32'hCCCC0003, 0, 0, 1, 32'h100, 32'hAAAA0001, 0, 2);
        tbl[7]  = mk(1, 32'h108, 32'hCCCC0003, 0, 0, 1, 32'h100, 32'hAAAA0001, 0, 3);
        tbl[8]  = mk(1, 32'h108, 32'hCCCC0003, 1, 0, 1, 32'h104, 32'hBBBB0002, 1, 3);
        tbl[9]  = mk(1, 32'h108, 32'hCCCC0003, 1, 0, 1, 32'h108, 32'hCCCC0003, 1, 3);
        tbl[10] = mk(0, 32'h000, 32'h00000000, 1, 0, 0, 32'h000, 32'h00000000, 1, 3);
        tbl[11] = mk(1, 32'h200, 32'h11110004, 0, 0, 1, 32'h200, 32'h11110004, 1, 3);
        tbl[12] = mk(1, 32'h204, 32'h22220005, 0, 0, 1, 32'h200, 32'h11110004, 0, 4);
        tbl[13] = mk(1, 32'h300, 32'h00000013, 0, 1, 0, 32'h000, 32'h00000000, 1, 4);
        tbl[14] = mk(0, 32'h000, 32'h00000000, 1, 0, 0, 32'h000, 32'h00000000, 1, 4);
        tbl[15] = mk(1, 32'h400, 32'h33330006, 1, 0, 1, 32'h400, 32'h33330006, 1, 4);
        tbl[16] = mk(1, 32'h404, 32'h44440007, 0, 1, 0, 32'h000, 32'h00000000, 1, 4);
        tbl[17] = mk(0, 32'h000, 32'h00000000, 0, 0, 0, 32'h000, 32'h00000000, 1, 4);

        // Reset state, sampled while reset is held.
        #2;
        chk("rst u1 dn_valid", {31'b0, if1.dn_valid}, 32'd0);
        chk("rst u1 up_ready", {31'b0, if1.up_ready}, 32'd1);
        chk("rst u1 stall_cnt", {16'b0, if1.stall_cnt}, 32'd0);
        chk("rst u1 dn_insn", if1.dn_insn, 32'd0);
        chk("rst u0 up_ready", {31'b0, if0.up_ready}, 32'd1);
        chk("rst u0 dn_valid", {31'b0, if0.dn_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            drive1(tbl[i].uv, tbl[i].pc, tbl[i].insn, tbl[i].dr, tbl[i].fl);
            tick();
            e_pc4 = tbl[i].e_dv ? tbl[i].e_pc + 32'd4 : 32'd0;
            chk($sformatf("row%0d dn_valid", i), {31'b0, if1.dn_valid}, {31'b0, tbl[i].e_dv});
            chk($sformatf("row%0d dn_pc", i), if1.dn_pc, tbl[i].e_pc);
            chk($sformatf("row%0d dn_pc_plus_4", i), if1.dn_pc_plus_4, e_pc4);
            chk($sformatf("row%0d dn_insn", i), if1.dn_insn, tbl[i].e_insn);
            chk($sformatf("row%0d up_ready", i), {31'b0, if1.up_ready}, {31'b0, tbl[i].e_ur});
            chk($sformatf("row%0d stall_cnt", i), {16'b0, if1.stall_cnt}, {16'b0, tbl[i].e_st});
        end

        // Fill u1 to FULL, then pulse reset mid-cycle.
        drive1(1'b1, 32'h500, 32'h55550008, 1'b0, 1'b0);
        tick();
        drive1(1'b1, 32'h504, 32'h66660009, 1'b0, 1'b0);
        tick();
        chk("full up_ready", {31'b0, if1.up_ready}, 32'd0);
        chk("full stall_cnt", {16'b0, if1.stall_cnt}, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst dn_valid", {31'b0, if1.dn_valid}, 32'd0);
        chk("arst stall_cnt", {16'b0, if1.stall_cnt}, 32'd0);
        chk("arst up_ready", {31'b0, if1.up_ready}, 32'd1);
        chk("arst dn_pc", if1.dn_pc, 32'd0);
        #2 rst_n = 1'b1;
        drive1(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        chk("post-arst dn_valid", {31'b0, if1.dn_valid}, 32'd0);
        chk("post-arst dn_insn", if1.dn_insn, 32'd0);

        // Single-register mode: up_ready is combinational on dn_ready.
        drive0(1'b1, 32'h600, 32'h7777000A, 1'b1);
        #1 chk("s0 a up_ready", {31'b0, if0.up_ready}, 32'd1);
        tick();
        chk("s0 a dn_pc", if0.dn_pc, 32'h600);
        drive0(1'b1, 32'h604, 32'h8888000B, 1'b0);
        #1 chk("s0 b up_ready", {31'b0, if0.up_ready}, 32'd0);
        tick();
        chk("s0 b dn_pc held", if0.dn_pc, 32'h600);
        chk("s0 b dn_insn held", if0.dn_insn, 32'h7777000A);
        drive0(1'b1, 32'h604, 32'h8888000B, 1'b1);
        #1 chk("s0 c up_ready", {31'b0, if0.up_ready}, 32'd1);
        tick();
        chk("s0 c dn_pc", if0.dn_pc, 32'h604);
        chk("s0 c dn_valid", {31'b0, if0.dn_valid}, 32'd1);
        drive0(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("s0 d dn_valid", {31'b0, if0.dn_valid}, 32'd0);
        chk("s0 d stall_cnt", {28'b0, if0.stall_cnt}, 32'd1);

        // Saturation of the 4-bit counter under 20 blocked cycles.
        drive0(1'b1, 32'h700, 32'h9999000C, 1'b1);
        tick();
        drive0(1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            e_sat = (1 + i > 15) ? 32'd15 : 32'(1 + i);
            chk($sformatf("sat cyc%0d stall_cnt", i), {28'b0, if0.stall_cnt}, e_sat);
        end
        chk("sat dn_pc held", if0.dn_pc, 32'h700);
        chk("sat dn_valid", {31'b0, if0.dn_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter PC_W, default 32, width of the PC and PC+4 fields.
REQ-002 SHALL have parameter INSN_W, default 32, width of the instruction field.
REQ-003 SHALL have parameter SKID, default 1; 1 selects a 2-entry skid buffer, 0 selects a single register.
REQ-004 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-005 SHALL have port sys_clk  input  1  sole clock; all state on its rising edge.
REQ-006 SHALL have port sys_rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port flush  input  1  kill all held entries; branch/jump redirect.
REQ-008 SHALL have port up_valid  input  1  upstream entry offered.
REQ-009 SHALL have port up_ready  output  1  stage accepts the upstream entry this cycle.
REQ-010 SHALL have ports up_pc, up_pc_plus_4  input  PC_W  upstream PC and PC+4.
REQ-011 SHALL have port up_insn  input  INSN_W  upstream instruction.
REQ-012 SHALL have port dn_valid  output  1  head entry valid.
REQ-013 SHALL have port dn_ready  input  1  downstream consumes the head entry.
REQ-014 SHALL have ports dn_pc, dn_pc_plus_4  output  PC_W, and dn_insn  output  INSN_W; head entry payload.
REQ-015 SHALL have port stall_cnt  output  CNT_W  saturating count of backpressure cycles.

Function
REQ-016 SHALL accept an entry when up_valid & up_ready, and emit one when dn_valid & dn_ready.
REQ-017 SHALL drive dn_* directly from the head register; latency is 1 cycle from acceptance to dn_valid, with no combinational up_*->dn_* path.
REQ-018 SHALL, for SKID=1, drive up_ready = ~skid_valid from a register only; no dn_ready->up_ready combinational path.
REQ-019 SHALL, for SKID=1, implement states EMPTY (0 entries), ONE (head only) and FULL (head+skid).
REQ-020 SHALL transition EMPTY->ONE on accept.
REQ-021 SHALL, in ONE, go to FULL on accept without emit, stay in ONE on accept with emit (head loads new entry), and go to EMPTY on emit without accept.
REQ-022 SHALL, in FULL, hold up_ready=0 and on emit move skid into head, going to ONE.
REQ-023 SHALL, for SKID=0, drive up_ready = ~dn_valid | dn_ready combinationally and have only states EMPTY and ONE.
REQ-024 SHALL preserve order: the skid entry always leaves after the head entry.
REQ-025 SHALL, on flush, go to EMPTY next cycle regardless of dn_ready, up_valid or state, zeroing all payload registers.
REQ-026 SHALL discard any upstream entry presented in a flush cycle, even if up_ready=1.
REQ-027 SHALL keep dn_valid=0 and zero payload (bubble) while EMPTY.
REQ-028 SHALL increment stall_cnt each cycle with dn_valid & ~dn_ready & ~flush, saturating at all-ones with no wrap.
REQ-029 SHALL leave stall_cnt unchanged by flush.

Reset
REQ-030 SHALL, with sys_rst_n low, asynchronously force state EMPTY, dn_valid=0, all payload=0, skid_valid=0 and stall_cnt=0.
REQ-031 SHALL drive up_ready=1 during reset for SKID=1, and for SKID=0 through REQ-023.
REQ-032 SHALL, if reset asserts mid-operation, drop all held entries, and SHALL accept no entry on the first edge after deassertion if deassertion coincides with that edge.

Structure
REQ-033 SHALL place the state encoding (EMPTY/ONE/FULL) and the default PC_W/INSN_W constants in the shared para package.
REQ-034 SHALL implement the counter as sub-module sat_counter (parameter W; ports inc, q; asynchronous active-low reset).
REQ-035 SHALL select the SKID=0/1 datapath with a generate block and instantiate no skid register when SKID=0.

Verification
REQ-036 SHALL cover streaming: SKID=1, up_valid=1, dn_ready=1 with PCs 0x0,0x4,0x8 -> dn_pc 0x0,0x4,0x8 on consecutive cycles, each 1 cycle after acceptance, up_ready constantly 1.
REQ-037 SHALL cover backpressure: SKID=1, dn_ready=0 for 4 cycles with entries A,B,C offered -> A in head, B in skid, up_ready=0 from cycle 2, C held upstream, stall_cnt=3; on release, output A,B,C in order.
REQ-038 SHALL cover flush while FULL: flush=1 with dn_ready=0 and up_valid=1 (insn 0x00000013) -> next cycle dn_valid=0, dn_insn=0, up_ready=1, entry not captured.
REQ-039 SHALL cover the single-register mode: SKID=0, dn_ready toggling 1,0,1 -> up_ready follows ~dn_valid|dn_ready in the same cycle, no loss or duplication.
REQ-040 SHALL cover saturation: CNT_W=4, dn_ready=0 for 20 cycles with dn_valid=1 -> stall_cnt stops at 15.
REQ-041 SHALL cover asynchronous reset: sys_rst_n pulsed low mid-cycle while FULL -> dn_valid=0 and stall_cnt=0 immediately, before the next sys_clk edge.
